irom_loader: RTL and testbench

- Write-side counterpart of the read-only instruction memory. Receives a framed byte stream (valid/ready), packs bytes little-endian into 32-bit words, and writes them to the instruction RAM's write port at consecutive word addresses from 0.
- Holds the CPU in reset while loading and releases it on success.
- Sits between the host byte source (UART RX / debug bridge) and the instruction RAM.

---
 rtl/irom_loader_pkg.sv | 22 ++
 rtl/irom_loader_if.sv | 21 ++
 rtl/irom_loader_word_packer.sv | 30 +++
 rtl/irom_loader.sv | 172 +++++++++++++++++
 tb/tb_irom_loader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irom_loader_pkg.sv
// Shared types and constants for the instruction-RAM loader.
package irom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    CHK   = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_CHK  = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

endpackage

// File: rtl/irom_loader_if.sv
// Byte stream in, instruction-RAM write port out.
interface irom_loader_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              irom_we;
  logic [ADDR_W-1:0] irom_waddr;
  logic [31:0]       irom_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, irom_we, irom_waddr, irom_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, irom_we, irom_waddr, irom_wdata
  );
endinterface

// File: rtl/irom_loader_word_packer.sv
// Little-endian byte-to-word packer; word_ready_o flags acceptance of lane 3.
module irom_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_we_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [3:0][7:0] lane_q;
  logic [1:0]      idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      idx_q  <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (byte_we_i) begin
      lane_q[idx_q] <= byte_i;
      idx_q         <= idx_q + 2'd1;
    end
  end

  assign word_o       = lane_q;
  assign word_ready_o = byte_we_i & (idx_q == 2'd3);

endmodule

// File: rtl/irom_loader.sv
// Framed byte-stream loader for the instruction RAM; holds the CPU in reset until done.
// Define IROM_LOADER_CHKSUM_EN to add the trailing XOR checksum byte.
module irom_loader
  import irom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DFLT
) (
  input  logic         clk,
  input  logic         rst_n,
  irom_loader_if.slave bus,
  input  logic         start,
  output logic         cpu_hold,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
`ifdef IROM_LOADER_CHKSUM_EN
  localparam state_e TAIL_ST = CHK;
`else
  localparam state_e TAIL_ST = DONE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [16:0]       remain_q, remain_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        err_code_q, err_code_d;
`ifdef IROM_LOADER_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic        in_ready;
  logic        accept;
  logic        start_ok;
  logic        tmo_active;
  logic [15:0] len_w;
  logic [31:0] word;
  logic        word_ready;

  assign in_ready   = (state_q == IDLE) || (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CHK);
  assign accept     = bus.in_valid & in_ready;
  assign start_ok   = start & ((state_q == DONE) || (state_q == ERR));
  assign tmo_active = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CHK);
  assign len_w      = {bus.in_data, len_lo_q};

  irom_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start_ok),
    .byte_we_i    (accept && (state_q == DATA)),
    .byte_i       (bus.in_data),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    len_lo_d   = len_lo_q;
    tmo_d      = tmo_q;
    err_code_d = err_code_q;
`ifdef IROM_LOADER_CHKSUM_EN
    chk_d      = chk_q;
    if (accept && (state_q != IDLE) && (state_q != CHK)) chk_d = chk_q ^ bus.in_data;
`endif
    if (tmo_active) tmo_d = accept ? '0 : tmo_q + 1'b1;

    case (state_q)
      IDLE: if (accept && (bus.in_data == SYNC_BYTE)) begin
        state_d = LEN0;
`ifdef IROM_LOADER_CHKSUM_EN
        chk_d   = '0;
`endif
      end
      LEN0: if (accept) begin
        len_lo_d = bus.in_data;
        state_d  = LEN1;
      end
      LEN1: if (accept) begin
        remain_d = {1'b0, len_w};
        if (len_w == 16'd0) begin
          state_d = TAIL_ST;
        end else if ({1'b0, len_w} > DEPTH) begin
          state_d    = ERR;
          err_code_d = ERR_LEN;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (word_ready) state_d = WRITE;
      // Address advances only between writes, so it rests on N-1 and never wraps at full depth.
      WRITE: begin
        remain_d = remain_q - 17'd1;
        if (remain_q == 17'd1) begin
          state_d = TAIL_ST;
        end else begin
          state_d = DATA;
          addr_d  = addr_q + 1'b1;
        end
      end
`ifdef IROM_LOADER_CHKSUM_EN
      CHK: if (accept) begin
        if (bus.in_data == chk_q) begin
          state_d = DONE;
        end else begin
          state_d    = ERR;
          err_code_d = ERR_CHK;
        end
      end
`endif
      DONE, ERR: if (start_ok) begin
        state_d    = IDLE;
        err_code_d = ERR_NONE;
        addr_d     = '0;
        remain_d   = '0;
`ifdef IROM_LOADER_CHKSUM_EN
        chk_d      = '0;
`endif
      end
      default: state_d = state_q;
    endcase

    if (tmo_active && !accept && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
      state_d    = ERR;
      err_code_d = ERR_TMO;
      tmo_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      len_lo_q   <= '0;
      tmo_q      <= '0;
      err_code_q <= ERR_NONE;
`ifdef IROM_LOADER_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      len_lo_q   <= len_lo_d;
      tmo_q      <= tmo_d;
      err_code_q <= err_code_d;
`ifdef IROM_LOADER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.irom_we    = (state_q == WRITE);
  assign bus.irom_waddr = addr_q;
  assign bus.irom_wdata = word;
  assign cpu_hold       = (state_q != DONE);
  assign done           = (state_q == DONE);
  assign err            = (state_q == ERR);
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_irom_loader.sv
// Scoreboard bench for irom_loader: expected writes queued at frame build, popped on irom_we.
module tb_irom_loader;
  import irom_loader_pkg::*;

  localparam int unsigned AW = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cpu_hold, done, err;
  logic [1:0] err_code;

  irom_loader_if #(.ADDR_W(AW)) bus ();

  irom_loader #(.ADDR_W(AW), .TIMEOUT(16), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .start    (start),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int unsigned       n_chk = 0;
  int unsigned       n_fail = 0;
  int unsigned       n_wr = 0;
  logic [AW+31:0]    exp_q[$];
  logic [7:0]        fb_q[$];
  bit                fl3_q[$];
  logic [31:0]       wq[$];
  logic [7:0]        chk_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [AW+31:0] e;
    if (rst_n && bus.irom_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {31'd0, bus.irom_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {18'd0, bus.irom_waddr}, {18'd0, e[AW+31:32]});
        check("wr_data", bus.irom_wdata, e[31:0]);
      end
    end
  end

  task automatic add(input logic [7:0] b, input bit l3);
    fb_q.push_back(b);
    fl3_q.push_back(l3);
  endtask

  // Frame from wq: SYNC, length, data, then (when compiled in) checksum XOR flip.
  task automatic build(input logic [15:0] len, input logic [7:0] flip);
    logic [7:0]  x;
    int unsigned a = 0;
    add(8'hA5, 1'b0);
    add(len[7:0], 1'b0);
    add(len[15:8], 1'b0);
    x = len[7:0] ^ len[15:8];
    while (wq.size() != 0) begin
      logic [31:0] w;
      w = wq.pop_front();
      exp_q.push_back({AW'(a), w});
      for (int i = 0; i < 4; i++) begin
        add(w[8*i +: 8], i == 3);
        x = x ^ w[8*i +: 8];
      end
      a++;
    end
    chk_byte = x ^ flip;
`ifdef IROM_LOADER_CHKSUM_EN
    add(chk_byte, 1'b0);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit l3);
    int unsigned bnd = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && bnd < 50) begin
      @(negedge clk);
      bnd++;
    end
    check("rdy_wait", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    if (l3) begin
      check("wr_latency", {31'd0, bus.irom_we}, 32'd1);
      check("bp_ready", {31'd0, bus.in_ready}, 32'd0);
    end
  endtask

  task automatic send_all();
    while (fb_q.size() != 0) send_byte(fb_q.pop_front(), fl3_q.pop_front());
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int unsigned b = 0;
    while (!(done | err) && b < 100) begin
      @(negedge clk);
      b++;
    end
    check(tag, {31'd0, done | err}, 32'd1);
  endtask

  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rs_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rs_hold", {31'd0, cpu_hold}, 32'd1);
    check("rs_done", {31'd0, done}, 32'd0);
    check("rs_err", {31'd0, err}, 32'd0);
    check("rs_code", {30'd0, err_code}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_we", {31'd0, bus.irom_we}, 32'd0);
    check("rst_waddr", {18'd0, bus.irom_waddr}, 32'd0);
    check("rst_wdata", bus.irom_wdata, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_code", {30'd0, err_code}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // two words, valid held high throughout
    wq.push_back(32'h12345678);
    wq.push_back(32'hDEADBEEF);
    build(16'd2, 8'h00);
    send_all();
    wait_end("t1_end");
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_hold", {31'd0, cpu_hold}, 32'd0);
    check("t1_ready", {31'd0, bus.in_ready}, 32'd0);
    check("t1_nwr", n_wr, 32'd2);
    restart();

    // leading garbage
    add(8'h00, 1'b0);
    add(8'hFF, 1'b0);
    wq.push_back(32'hCAFEF00D);
    build(16'd1, 8'h00);
    send_all();
    wait_end("t2_end");
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_nwr", n_wr, 32'd3);
    restart();

    // zero-length frame
    build(16'd0, 8'h00);
    send_all();
    wait_end("t3_end");
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_nwr", n_wr, 32'd3);
    restart();

    // length beyond depth
    add(8'hA5, 1'b0);
    add(8'h01, 1'b0);
    add(8'h40, 1'b0);
    send_all();
    check("len_err", {31'd0, err}, 32'd1);
    check("len_code", {30'd0, err_code}, {30'd0, ERR_LEN});
    check("len_hold", {31'd0, cpu_hold}, 32'd1);
    check("len_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("len_nwr", n_wr, 32'd3);
    restart();

    // stall after two data bytes
    add(8'hA5, 1'b0);
    add(8'h01, 1'b0);
    add(8'h00, 1'b0);
    add(8'h11, 1'b0);
    add(8'h22, 1'b0);
    send_all();
    repeat (15) @(negedge clk);
    check("tmo_early", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_code", {30'd0, err_code}, {30'd0, ERR_TMO});
    check("tmo_hold", {31'd0, cpu_hold}, 32'd1);
    check("tmo_nwr", n_wr, 32'd3);
    restart();

    w0 = n_wr;
`ifdef IROM_LOADER_CHKSUM_EN
    wq.push_back(32'h04030201);
    build(16'd1, 8'h00);
    send_all();
    wait_end("ck_ok_end");
    check("ck_ok_done", {31'd0, done}, 32'd1);
    restart();
    wq.push_back(32'h04030201);
    build(16'd1, 8'h03);
    send_all();
    wait_end("ck_bad_end");
    check("ck_bad_err", {31'd0, err}, 32'd1);
    check("ck_bad_code", {30'd0, err_code}, {30'd0, ERR_CHK});
    check("ck_nwr", n_wr, w0 + 2);
    restart();
`endif

    // reset mid-load discards the partial word
    add(8'hA5, 1'b0);
    add(8'h01, 1'b0);
    add(8'h00, 1'b0);
    add(8'h11, 1'b0);
    send_all();
    rst_n = 1'b0;
    #1;
    check("mr_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mr_wdata", bus.irom_wdata, 32'd0);
    check("mr_hold", {31'd0, cpu_hold}, 32'd1);
    check("mr_we", {31'd0, bus.irom_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
